// File: rtl/mem_access_stage_if.sv
// ---------------------------------------------------------------------------
// mem_access_stage_if
// Data-memory bus between the memory stage (master) and the data memory
// (slave). Simple req/ready handshake: the master holds dmem_req and all
// request fields stable until the slave answers with dmem_ready.
//
//   dmem_req    master->slave  request active
//   dmem_we     master->slave  1 = write, 0 = read
//   dmem_addr   master->slave  word-aligned address
//   dmem_be     master->slave  byte enables (all ones for reads)
//   dmem_wdata  master->slave  lane-replicated store data
//   dmem_rdata  slave->master  read data, valid with dmem_ready
//   dmem_ready  slave->master  access completes this cycle
// ---------------------------------------------------------------------------
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_be,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ready
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_be,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ready
    );
endinterface

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
// Memory stage between EX/MEM and MEM/WB. Non-memory instructions pass
// through with one cycle of latency. Loads/stores are checked for alignment
// and legal funct3, then issued on the data bus (IDLE -> ACCESS -> DONE);
// the pipeline is stalled while the access is pending. Load data is
// formatted per funct3 and registered for writeback. A bus that stays silent
// for TIMEOUT_CYCLES ACCESS cycles aborts the access with bus_err_out.
//
// Ports
//   clk, reset          clock; asynchronous active-low reset
//   *_in                EX/MEM fields (held stable by upstream while stall_out)
//   dmem                data-memory bus (master side)
//   stall_out           combinational stall request to upstream
//   *_out               registered MEM/WB fields
//   misalign_out        1-cycle pulse: misaligned or illegal-funct3 access
//   bus_err_out         1-cycle pulse: bus timeout
// ---------------------------------------------------------------------------
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      RegWrite_in,
    input  logic                      MemtoReg_in,
    input  logic                      MemWrite_in,
    input  logic                      MemRead_in,
    input  logic [31:0]               ALUResult_in,
    input  logic [31:0]               WriteData_in,
    input  logic [4:0]                Rd_in,
    input  logic [2:0]                funct3_in,
    mem_access_stage_if.master        dmem,
    output logic                      stall_out,
    output logic                      RegWrite_out,
    output logic                      MemtoReg_out,
    output logic [31:0]               ReadData_out,
    output logic [31:0]               ALUResult_out,
    output logic [4:0]                Rd_out,
    output logic                      misalign_out,
    output logic                      bus_err_out
);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACCESS = 2'b01;
    localparam logic [1:0] ST_DONE   = 2'b10;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Extract and extend the addressed byte/half of a read word.
    function automatic logic [31:0] load_format(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] rd);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res_v;
        case (off)
            2'd0:    byte_v = rd[7:0];
            2'd1:    byte_v = rd[15:8];
            2'd2:    byte_v = rd[23:16];
            default: byte_v = rd[31:24];
        endcase
        half_v = off[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  res_v = {{24{byte_v[7]}}, byte_v};
            3'b100:  res_v = {24'h000000, byte_v};
            3'b001:  res_v = {{16{half_v[15]}}, half_v};
            3'b101:  res_v = {16'h0000, half_v};
            3'b010:  res_v = rd;
            default: res_v = 32'h0000_0000;
        endcase
        return res_v;
    endfunction

    logic [1:0]       state_r,    state_nxt_s;
    logic [CNT_W-1:0] cnt_r,      cnt_nxt_s;
    logic             req_r,      req_nxt_s;
    logic             we_r,       we_nxt_s;
    logic [31:0]      addr_r,     addr_nxt_s;
    logic [3:0]       be_r,       be_nxt_s;
    logic [31:0]      wdata_r,    wdata_nxt_s;
    logic [2:0]       f3_r,       f3_nxt_s;
    logic [1:0]       off_r,      off_nxt_s;
    logic [31:0]      rdata_r,    rdata_nxt_s;
    logic             timeout_r,  timeout_nxt_s;

    logic             reg_write_r,  reg_write_nxt_s;
    logic             mem_to_reg_r, mem_to_reg_nxt_s;
    logic [31:0]      read_data_r,  read_data_nxt_s;
    logic [31:0]      alu_result_r, alu_result_nxt_s;
    logic [4:0]       rd_r,         rd_nxt_s;
    logic             misalign_r,   misalign_nxt_s;
    logic             bus_err_r,    bus_err_nxt_s;

    logic             memop_s;
    logic             is_store_s;
    logic             fault_s;
    logic [3:0]       be_s;
    logic [31:0]      wdata_s;

    assign memop_s    = MemRead_in | MemWrite_in;
    // A simultaneous read+write request is treated as a store.
    assign is_store_s = MemWrite_in;

    // Fault detection: illegal funct3 for the direction, or misaligned address.
    always_comb begin
        fault_s = 1'b0;
        if (is_store_s) begin
            case (funct3_in)
                3'b000:  fault_s = 1'b0;
                3'b001:  fault_s = ALUResult_in[0];
                3'b010:  fault_s = |ALUResult_in[1:0];
                default: fault_s = 1'b1;
            endcase
        end else begin
            case (funct3_in)
                3'b000, 3'b100: fault_s = 1'b0;
                3'b001, 3'b101: fault_s = ALUResult_in[0];
                3'b010:         fault_s = |ALUResult_in[1:0];
                default:        fault_s = 1'b1;
            endcase
        end
    end

    // Byte enables and lane-replicated write data for the request being issued.
    always_comb begin
        be_s    = 4'b1111;
        wdata_s = WriteData_in;
        if (is_store_s) begin
            case (funct3_in[1:0])
                2'b00: begin
                    be_s    = 4'b0001 << ALUResult_in[1:0];
                    wdata_s = {4{WriteData_in[7:0]}};
                end
                2'b01: begin
                    be_s    = 4'b0011 << ALUResult_in[1:0];
                    wdata_s = {2{WriteData_in[15:0]}};
                end
                default: begin
                    be_s    = 4'b1111;
                    wdata_s = WriteData_in;
                end
            endcase
        end else begin
            be_s    = 4'b1111;
            wdata_s = WriteData_in;
        end
    end

    // FSM next state, bus request fields and next values of the MEM/WB outputs.
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        req_nxt_s        = req_r;
        we_nxt_s         = we_r;
        addr_nxt_s       = addr_r;
        be_nxt_s         = be_r;
        wdata_nxt_s      = wdata_r;
        f3_nxt_s         = f3_r;
        off_nxt_s        = off_r;
        rdata_nxt_s      = rdata_r;
        timeout_nxt_s    = timeout_r;
        stall_out        = 1'b0;
        // Bubble unless a branch below says otherwise.
        reg_write_nxt_s  = 1'b0;
        mem_to_reg_nxt_s = 1'b0;
        read_data_nxt_s  = 32'h0000_0000;
        alu_result_nxt_s = 32'h0000_0000;
        rd_nxt_s         = 5'd0;
        misalign_nxt_s   = 1'b0;
        bus_err_nxt_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (!memop_s) begin
                    reg_write_nxt_s  = RegWrite_in;
                    mem_to_reg_nxt_s = MemtoReg_in;
                    alu_result_nxt_s = ALUResult_in;
                    rd_nxt_s         = Rd_in;
                end else if (fault_s) begin
                    // Rejected without touching the bus; only the write is squashed.
                    misalign_nxt_s   = 1'b1;
                    mem_to_reg_nxt_s = MemtoReg_in;
                    alu_result_nxt_s = ALUResult_in;
                    rd_nxt_s         = Rd_in;
                end else begin
                    stall_out     = 1'b1;
                    req_nxt_s     = 1'b1;
                    we_nxt_s      = is_store_s;
                    addr_nxt_s    = {ALUResult_in[31:2], 2'b00};
                    be_nxt_s      = be_s;
                    wdata_nxt_s   = wdata_s;
                    f3_nxt_s      = funct3_in;
                    off_nxt_s     = ALUResult_in[1:0];
                    rdata_nxt_s   = 32'h0000_0000;
                    timeout_nxt_s = 1'b0;
                    cnt_nxt_s     = '0;
                    state_nxt_s   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                stall_out = 1'b1;
                if (dmem.dmem_ready) begin
                    req_nxt_s   = 1'b0;
                    rdata_nxt_s = we_r ? 32'h0000_0000 : load_format(f3_r, off_r, dmem.dmem_rdata);
                    state_nxt_s = ST_DONE;
                end else if (cnt_r == CNT_LAST) begin
                    req_nxt_s     = 1'b0;
                    bus_err_nxt_s = 1'b1;
                    timeout_nxt_s = 1'b1;
                    state_nxt_s   = ST_DONE;
                end else begin
                    cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                // Upstream still holds this instruction's fields during DONE.
                reg_write_nxt_s  = RegWrite_in & ~timeout_r;
                mem_to_reg_nxt_s = MemtoReg_in;
                read_data_nxt_s  = rdata_r;
                alu_result_nxt_s = ALUResult_in;
                rd_nxt_s         = Rd_in;
                cnt_nxt_s        = '0;
                state_nxt_s      = ST_IDLE;
            end
            default: begin
                req_nxt_s   = 1'b0;
                cnt_nxt_s   = '0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, bus request registers and MEM/WB output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            req_r        <= 1'b0;
            we_r         <= 1'b0;
            addr_r       <= 32'h0000_0000;
            be_r         <= 4'b0000;
            wdata_r      <= 32'h0000_0000;
            f3_r         <= 3'b000;
            off_r        <= 2'b00;
            rdata_r      <= 32'h0000_0000;
            timeout_r    <= 1'b0;
            reg_write_r  <= 1'b0;
            mem_to_reg_r <= 1'b0;
            read_data_r  <= 32'h0000_0000;
            alu_result_r <= 32'h0000_0000;
            rd_r         <= 5'd0;
            misalign_r   <= 1'b0;
            bus_err_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            req_r        <= req_nxt_s;
            we_r         <= we_nxt_s;
            addr_r       <= addr_nxt_s;
            be_r         <= be_nxt_s;
            wdata_r      <= wdata_nxt_s;
            f3_r         <= f3_nxt_s;
            off_r        <= off_nxt_s;
            rdata_r      <= rdata_nxt_s;
            timeout_r    <= timeout_nxt_s;
            reg_write_r  <= reg_write_nxt_s;
            mem_to_reg_r <= mem_to_reg_nxt_s;
            read_data_r  <= read_data_nxt_s;
            alu_result_r <= alu_result_nxt_s;
            rd_r         <= rd_nxt_s;
            misalign_r   <= misalign_nxt_s;
            bus_err_r    <= bus_err_nxt_s;
        end
    end

    assign dmem.dmem_req   = req_r;
    assign dmem.dmem_we    = we_r;
    assign dmem.dmem_addr  = addr_r;
    assign dmem.dmem_be    = be_r;
    assign dmem.dmem_wdata = wdata_r;

    assign RegWrite_out  = reg_write_r;
    assign MemtoReg_out  = mem_to_reg_r;
    assign ReadData_out  = read_data_r;
    assign ALUResult_out = alu_result_r;
    assign Rd_out        = rd_r;
    assign misalign_out  = misalign_r;
    assign bus_err_out   = bus_err_r;

endmodule
